hash_msg_packer: RTL
====================

Name: hash_msg_packer

Overview:
- Upstream feeder for the Keccak padder in the hash_192 path.
- Accepts the message as a byte stream with a valid/ready handshake and packs it big-endian into 192-bit words.
- Presents each word to the padder as in / in_ready / is_last / byte_num and honours the padder's buffer_full backpressure.
- Handles exactly one message per reset, matching the padder, which is also reset per message.

Parameters:
- WORD_BYTES, 24, bytes per output word; the output word width is WORD_BYTES*8 = 192.
- CNT_W, 6, width of the byte counter and of word_bytes; must satisfy 2^CNT_W > WORD_BYTES.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- s_data  input  8  message byte.
- s_valid  input  1  s_data is valid.
- s_last  input  1  with s_valid, marks the final message byte.
- s_ready  output  1  packer accepts a byte this cycle.
- word  output  192  packed word to padder `in`; the first byte sits at [191:184].
- word_valid  output  1  drives padder `in_ready`.
- word_last  output  1  drives padder `is_last`.
- word_bytes  output  CNT_W  drives padder `byte_num`; the count of valid bytes, meaningful only when word_last=1.
- buffer_full  input  1  from the padder; stall while high.
- done  output  1  final word accepted by the padder; held until reset.

Behaviour:
- Byte acceptance: a byte is taken when s_valid & s_ready. A word is taken by the padder when word_valid & ~buffer_full.
- Reset values:
  - word=0, word_valid=0, word_last=0, word_bytes=0, done=0, s_ready=0.
  - Internal count=0, state=FILL.
  - s_ready rises 1 cycle after reset deasserts.
- FILL state:
  - s_ready=1.
  - An accepted byte is written at byte position count, i.e. bits [191-8*count -: 8], and count increments.
  - The accepted byte makes count reach 24 with s_last=0 -> SEND; the next cycle shows word_valid=1, word_last=0.
  - An accepted byte with s_last=1 and new count k<24 -> SEND; word_last=1, word_bytes=k, bytes at positions k..23 are zero.
  - An accepted byte with s_last=1 and k==24 -> SEND_FULL_THEN_TAIL; the full word is sent with word_last=0.
- SEND / SEND_FULL_THEN_TAIL states:
  - s_ready=0, and word, word_last and word_bytes are held stable while word_valid=1.
  - On acceptance from SEND with word_last=0: clear the accumulator, set count=0, go to FILL.
  - On acceptance from SEND with word_last=1: go to DONE.
  - On acceptance from SEND_FULL_THEN_TAIL: go to TAIL.
- TAIL state: word=0, word_valid=1, word_last=1, word_bytes=0. On acceptance, go to DONE.
- DONE state:
  - s_ready=0, word_valid=0, done=1.
  - Leaves DONE only on reset. Further s_valid input is ignored and never accepted.
- Latency: 1 cycle from accepting the completing byte to word_valid. Minimum of 1 idle byte cycle per word (the SEND cycle).
- buffer_full high for N cycles extends SEND/TAIL by N cycles with outputs unchanged. buffer_full is ignored when word_valid=0.
- s_last on a byte while s_valid=0 has no effect.
- A zero-length message is unsupported; the first accepted byte starts the message.
- Reset mid-operation discards partial data and returns to FILL with all outputs at their reset values the next cycle.

Optional Feature:
- PACKER_LEN_COUNT_EN defined:
  - Adds output msg_len[15:0], counting accepted message bytes.
  - msg_len saturates at 16'hFFFF and is reset to 0.
  - Adds output len_ovf, which goes to 1 and stays there when saturation is reached.
- Not defined: neither port exists and the counter logic is absent. All other behaviour is identical.

Test Plan:
- 3 bytes 90,AB,CD with last on CD:
  - Expect 1 word: word=192'h90ABCD00..00, word_last=1, word_bytes=3.
  - Then done=1, and padder out_ready yields out=({24'h90ABCD,8'h06,536'h0,8'h80}) through the padder's padding rule.
- 24 bytes 00..17 with last on 17:
  - Expect word 0x000102..17 with word_last=0.
  - Then a tail word=0, word_last=1, word_bytes=0, then done=1.
- 30 bytes:
  - First word, 24 bytes, with last=0.
  - Second word with bytes 18..1D at [191:144], word_last=1, word_bytes=6.
- buffer_full held high for 5 cycles during SEND:
  - word_valid stays 1 and word is stable, s_ready stays 0.
  - Acceptance happens on the cycle buffer_full falls.
- Assert reset after 10 bytes, then send 2 new bytes with last:
  - Output word holds only the 2 new bytes and word_bytes=2.
  - No trace of the first message appears.
- With PACKER_LEN_COUNT_EN defined, 30-byte message: msg_len=30 and len_ovf=0 at done.

Source files
------------

// File: rtl/hash_msg_packer_if.sv
// hash_msg_packer_if: byte-stream input and padder-facing word output of the message packer.
// Optional PACKER_LEN_COUNT_EN adds msg_len/len_ovf.
interface hash_msg_packer_if #(
    parameter int WORD_BYTES = 24,
    parameter int CNT_W      = 6
);
    logic [7:0]              s_data;
    logic                    s_valid;
    logic                    s_last;
    logic                    s_ready;
    logic [WORD_BYTES*8-1:0] word;
    logic                    word_valid;
    logic                    word_last;
    logic [CNT_W-1:0]        word_bytes;
    logic                    buffer_full;
    logic                    done;
`ifdef PACKER_LEN_COUNT_EN
    logic [15:0]             msg_len;
    logic                    len_ovf;
`endif

    modport master (
        input  s_data, s_valid, s_last, buffer_full,
        output s_ready, word, word_valid, word_last, word_bytes, done
`ifdef PACKER_LEN_COUNT_EN
        , output msg_len, len_ovf
`endif
    );

    modport slave (
        output s_data, s_valid, s_last, buffer_full,
        input  s_ready, word, word_valid, word_last, word_bytes, done
`ifdef PACKER_LEN_COUNT_EN
        , input msg_len, len_ovf
`endif
    );
endinterface

// File: rtl/hash_msg_packer.sv
// hash_msg_packer: packs one byte-stream message big-endian into 192-bit padder words.
// Optional PACKER_LEN_COUNT_EN adds a saturating accepted-byte counter (msg_len/len_ovf).
module hash_msg_packer #(
    parameter int WORD_BYTES = 24,
    parameter int CNT_W      = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    hash_msg_packer_if.master    bus
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(WORD_BYTES);

    typedef enum logic [2:0] {FILL, SEND, SEND_FULL, TAIL, DONE} state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [WORD_BYTES*8-1:0] word_q, fill_d;
    logic                    word_valid_q, word_last_q, done_q, s_ready_q;
    logic [CNT_W-1:0]        word_bytes_q;
    logic                    byte_take, word_take;

    assign byte_take = bus.s_valid & s_ready_q;
    assign word_take = word_valid_q & ~bus.buffer_full;
    assign count_d   = count_q + 1'b1;

    always_comb begin
        fill_d = word_q;
        for (int i = 0; i < WORD_BYTES; i++)
            if (count_q == CNT_W'(i)) fill_d[(WORD_BYTES-1-i)*8 +: 8] = bus.s_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FILL;
            count_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            word_last_q  <= 1'b0;
            word_bytes_q <= '0;
            done_q       <= 1'b0;
            s_ready_q    <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    s_ready_q <= 1'b1;
                    if (byte_take) begin
                        word_q       <= fill_d;
                        count_q      <= count_d;
                        word_bytes_q <= count_d;
                        if (bus.s_last || count_d == FULL) begin
                            s_ready_q    <= 1'b0;
                            word_valid_q <= 1'b1;
                            // a last byte that fills the word still needs an empty tail word
                            word_last_q  <= bus.s_last && count_d != FULL;
                            state_q      <= (bus.s_last && count_d == FULL) ? SEND_FULL : SEND;
                        end
                    end
                end
                SEND: if (word_take) begin
                    word_valid_q <= 1'b0;
                    if (word_last_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q   <= FILL;
                        word_q    <= '0;
                        count_q   <= '0;
                        s_ready_q <= 1'b1;
                    end
                end
                SEND_FULL: if (word_take) begin
                    word_q       <= '0;
                    word_last_q  <= 1'b1;
                    word_bytes_q <= '0;
                    state_q      <= TAIL;
                end
                TAIL: if (word_take) begin
                    word_valid_q <= 1'b0;
                    done_q       <= 1'b1;
                    state_q      <= DONE;
                end
                DONE: ;
                default: state_q <= FILL;
            endcase
        end
    end

    assign bus.s_ready    = s_ready_q;
    assign bus.word       = word_q;
    assign bus.word_valid = word_valid_q;
    assign bus.word_last  = word_last_q;
    assign bus.word_bytes = word_bytes_q;
    assign bus.done       = done_q;

`ifdef PACKER_LEN_COUNT_EN
    logic [15:0] msg_len_q;
    logic        len_ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            msg_len_q <= '0;
            len_ovf_q <= 1'b0;
        end else if (byte_take && msg_len_q != 16'hFFFF) begin
            msg_len_q <= msg_len_q + 16'd1;
            len_ovf_q <= len_ovf_q | (msg_len_q == 16'hFFFE);
        end
    end

    assign bus.msg_len = msg_len_q;
    assign bus.len_ovf = len_ovf_q;
`endif
endmodule
